dmem_mmio_ctrl: RTL and testbench
=================================

Name: dmem_mmio_ctrl

Overview:
- Data-memory stage downstream of the pipelined core's MEM stage.
- Consumes the core's single-cycle memory port (write enable, ALU address, store data) and returns read data combinationally, so the core can register it into MEM/WB the same cycle.
- Contains a local word RAM and a memory-mapped posted-write TX FIFO, drained to a peripheral over a valid/ready handshake.
- The core cannot stall on memory, so every access completes in one cycle.

Parameters:
- RAM_WORDS, 256, local RAM depth in 32-bit words (power of 2).
- FIFO_DEPTH, 4, TX FIFO entries (power of 2, >=2).

Ports:
- clk  input  1  core clock, all state on rising edge.
- rst  input  1  synchronous reset, active-high.
- mem_w_en  input  1  store strobe from EX/MEM.
- mem_addr  input  32  byte address (EX/MEM ALU result).
- mem_w_data  input  32  store data.
- mem_r_data  output  32  load data, combinational from mem_addr.
- io_valid  output  1  TX FIFO head valid.
- io_data  output  32  TX FIFO head word.
- io_ready  input  1  peripheral accepts head when high with io_valid.
- irq_ovf  output  1  sticky overflow flag (same as status bit 31).

Behaviour:
- Clock is clk. Reset is synchronous and active-high on rst, sampled on the clk rising edge.
- Address decode; mem_addr[1:0] is ignored (word accesses only):
  - mem_addr[31]=0: RAM. Word index is mem_addr[log2(RAM_WORDS)+1:2]. Upper bits are not decoded; the RAM aliases.
  - mem_addr[31]=1, mem_addr[3:2]=0: TXDATA. Write pushes mem_w_data. Read returns 0.
  - mem_addr[31]=1, mem_addr[3:2]=1: STATUS.
    - Read returns bit31=overflow, bit17=empty, bit16=full, bits[15:0]=count, other bits 0.
    - Write with mem_w_data[31]=1 clears overflow. Other bits are ignored.
  - mem_addr[31]=1, mem_addr[3:2]=2 or 3: reads 0, writes ignored.
- RAM:
  - Write takes effect at the posedge when mem_w_en=1.
  - Read is asynchronous and shows old data during a same-cycle write to the same word. New data is visible the cycle after.
  - RAM contents are not cleared by reset. Initial content is undefined; the bench must write before reading.
- TX FIFO:
  - Circular buffer with write/read pointers and a count of 0..FIFO_DEPTH. Pointers wrap modulo FIFO_DEPTH.
  - push = mem_w_en & TXDATA decode.
  - pop = io_valid & io_ready.
  - io_valid = (count != 0), driven from registered count, so it rises 1 cycle after the first push into an empty FIFO.
  - io_data = entry at the read pointer. It is held stable while io_valid & !io_ready.
  - Push and pop in the same cycle with count=FIFO_DEPTH: push is accepted, count is unchanged, no overflow.
  - Push and pop in the same cycle with 0<count<FIFO_DEPTH: count is unchanged, order is preserved.
  - Push with count=FIFO_DEPTH and no pop: data is dropped, pointers and count are unchanged, overflow is set at the next edge.
  - Push on an empty FIFO: a same-cycle pop is impossible (io_valid=0).
- Overflow:
  - Sticky; cleared only by reset or by a STATUS write with bit31=1.
  - The core issues at most one write per cycle, so set and clear cannot coincide.
  - irq_ovf = overflow register.
- Reset values:
  - count=0, pointers=0, overflow=0.
  - io_valid=0, irq_ovf=0.
  - io_data=don't-care, but FIFO storage is cleared to 0 so io_data=0.
  - mem_r_data for STATUS reads 0x00020000 after reset.
- Reset mid-operation: pending FIFO entries are discarded and io_valid drops the cycle after rst is sampled high. RAM is retained.
- Latency:
  - Load data: 0 cycles, combinational.
  - Push to io_valid: 1 cycle.
  - Pop to the next head on io_data: 1 cycle.

Test Plan:
- Reset, then read STATUS (0x80000004) -> mem_r_data=0x00020000; io_valid=0; irq_ovf=0.
- Write 0x12345678 to 0x00000010, read 0x00000010 next cycle -> 0x12345678. Read alias 0x00000410 (RAM_WORDS=256) -> 0x12345678. Same-cycle read during the write -> prior value.
- io_ready=0; push 0xA1,0xA2,0xA3,0xA4 to 0x80000000 -> io_valid rises 1 cycle after first push; STATUS=0x00010004. Fifth push 0xA5 -> STATUS=0x80010004, irq_ovf=1, 0xA5 never appears on io_data.
- From full, raise io_ready for 4 cycles -> io_data sequence 0xA1,0xA2,0xA3,0xA4, then io_valid=0, STATUS=0x80020000. Write 0x80000000 to STATUS -> STATUS=0x00020000, irq_ovf=0.
- FIFO full, io_ready=1, push 0xB0 the same cycle -> no overflow, count stays 4, 0xB0 emerges after 0xA2..0xA4.
- Push 2 words, assert rst for one cycle mid-drain -> next cycle io_valid=0, STATUS=0x00020000; earlier RAM word 0x00000010 still reads 0x12345678.

Source files
------------

// File: rtl/dmem_mmio_ctrl.sv
// Data-memory stage: local word RAM plus a memory-mapped posted-write TX FIFO.
// Every access completes in one cycle; load data is combinational from mem_addr.
module dmem_mmio_ctrl #(
  parameter int unsigned RAM_WORDS  = 256,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_w_en,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_w_data,
  output logic [31:0] mem_r_data,
  output logic        io_valid,
  output logic [31:0] io_data,
  input  logic        io_ready,
  output logic        irq_ovf
);

  localparam int unsigned RAM_AW  = $clog2(RAM_WORDS);
  localparam int unsigned FIFO_AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W   = FIFO_AW + 1;

  logic [31:0]        ram [RAM_WORDS];
  logic [31:0]        fifo_mem [FIFO_DEPTH];
  logic [FIFO_AW-1:0] wptr;
  logic [FIFO_AW-1:0] rptr;
  logic [CNT_W-1:0]   count;
  logic               overflow;

  logic [RAM_AW-1:0]  ram_idx;
  logic               io_sel;
  logic               is_tx;
  logic               is_status;
  logic               push;
  logic               pop;
  logic               full;
  logic               empty;
  logic               accept;
  logic [31:0]        status_word;
  logic               unused_addr;

  assign ram_idx     = mem_addr[RAM_AW+1:2];
  assign io_sel      = mem_addr[31];
  assign is_tx       = io_sel && (mem_addr[3:2] == 2'd0);
  assign is_status   = io_sel && (mem_addr[3:2] == 2'd1);
  assign unused_addr = ^{mem_addr[30:RAM_AW+2], mem_addr[1:0]};

  assign full   = (count == CNT_W'(FIFO_DEPTH));
  assign empty  = (count == '0);
  assign push   = mem_w_en && is_tx;
  assign pop    = io_valid && io_ready;
  // A push into a full FIFO still lands when the head leaves in the same cycle.
  assign accept = push && (!full || pop);

  assign io_valid = !empty;
  assign io_data  = fifo_mem[rptr];
  assign irq_ovf  = overflow;

  assign status_word = {overflow, 13'b0, empty, full, {(16-CNT_W){1'b0}}, count};

  always_comb begin
    mem_r_data = '0;
    if (!io_sel)
      mem_r_data = ram[ram_idx];
    else if (is_status)
      mem_r_data = status_word;
  end

  always_ff @(posedge clk) begin
    if (mem_w_en && !io_sel)
      ram[ram_idx] <= mem_w_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr     <= '0;
      rptr     <= '0;
      count    <= '0;
      overflow <= 1'b0;
      for (int unsigned i = 0; i < FIFO_DEPTH; i++)
        fifo_mem[i] <= '0;
    end else begin
      if (accept) begin
        fifo_mem[wptr] <= mem_w_data;
        wptr           <= wptr + 1'b1;
      end
      if (pop)
        rptr <= rptr + 1'b1;
      case ({accept, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (push && full && !pop)
        overflow <= 1'b1;
      else if (mem_w_en && is_status && mem_w_data[31])
        overflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_dmem_mmio_ctrl.sv
// Directed bench for dmem_mmio_ctrl: inputs driven and outputs sampled on the falling edge.
module tb_dmem_mmio_ctrl;

  localparam logic [31:0] TXDATA = 32'h8000_0000;
  localparam logic [31:0] STATUS = 32'h8000_0004;

  logic        clk;
  logic        rst;
  logic        mem_w_en;
  logic [31:0] mem_addr;
  logic [31:0] mem_w_data;
  logic [31:0] mem_r_data;
  logic        io_valid;
  logic [31:0] io_data;
  logic        io_ready;
  logic        irq_ovf;

  int n_cmp = 0;
  int n_err = 0;

  dmem_mmio_ctrl #(.RAM_WORDS(256), .FIFO_DEPTH(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .mem_w_en   (mem_w_en),
    .mem_addr   (mem_addr),
    .mem_w_data (mem_w_data),
    .mem_r_data (mem_r_data),
    .io_valid   (io_valid),
    .io_data    (io_data),
    .io_ready   (io_ready),
    .irq_ovf    (irq_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic test_reset();
    rst = 1'b1; mem_w_en = 1'b0; mem_addr = '0; mem_w_data = '0; io_ready = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    mem_addr = STATUS;
    #1;
    n_cmp++; if (mem_r_data !== 32'h0002_0000) begin n_err++; $display("FAIL reset_status: got %h expected %h", mem_r_data, 32'h0002_0000); end
    n_cmp++; if (io_valid !== 1'b0) begin n_err++; $display("FAIL reset_io_valid: got %b expected 0", io_valid); end
    n_cmp++; if (irq_ovf !== 1'b0) begin n_err++; $display("FAIL reset_irq: got %b expected 0", irq_ovf); end
    n_cmp++; if (io_data !== 32'h0) begin n_err++; $display("FAIL reset_io_data: got %h expected 0", io_data); end
  endtask

  task automatic test_ram();
    @(negedge clk);
    mem_w_en = 1'b1; mem_addr = 32'h10; mem_w_data = 32'h0BAD_F00D;
    @(negedge clk);
    mem_w_data = 32'h1234_5678;
    #1;
    n_cmp++; if (mem_r_data !== 32'h0BAD_F00D) begin n_err++; $display("FAIL ram_same_cycle_old: got %h expected %h", mem_r_data, 32'h0BAD_F00D); end
    @(negedge clk);
    mem_w_en = 1'b0;
    #1;
    n_cmp++; if (mem_r_data !== 32'h1234_5678) begin n_err++; $display("FAIL ram_read: got %h expected %h", mem_r_data, 32'h1234_5678); end
    mem_addr = 32'h410;
    #1;
    n_cmp++; if (mem_r_data !== 32'h1234_5678) begin n_err++; $display("FAIL ram_alias: got %h expected %h", mem_r_data, 32'h1234_5678); end
    mem_addr = 32'h14;
    mem_w_en = 1'b1; mem_w_data = 32'hCAFE_0014;
    @(negedge clk);
    mem_w_en = 1'b0; mem_addr = 32'h8000_0008;
    #1;
    n_cmp++; if (mem_r_data !== 32'h0) begin n_err++; $display("FAIL unmapped_read: got %h expected 0", mem_r_data); end
    mem_addr = 32'h10;
    #1;
    n_cmp++; if (mem_r_data !== 32'h1234_5678) begin n_err++; $display("FAIL ram_neighbour_intact: got %h expected %h", mem_r_data, 32'h1234_5678); end
    mem_addr = 32'h14;
    #1;
    n_cmp++; if (mem_r_data !== 32'hCAFE_0014) begin n_err++; $display("FAIL ram_word5: got %h expected %h", mem_r_data, 32'hCAFE_0014); end
  endtask

  task automatic test_fifo_fill();
    logic [31:0] vals [4];
    vals[0] = 32'hA1; vals[1] = 32'hA2; vals[2] = 32'hA3; vals[3] = 32'hA4;
    io_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      mem_w_en = 1'b1; mem_addr = TXDATA; mem_w_data = vals[i];
      #1;
      if (i == 0) begin
        n_cmp++; if (io_valid !== 1'b0) begin n_err++; $display("FAIL valid_before_push: got %b expected 0", io_valid); end
        mem_addr = 32'h8000_0000;
        #1;
        n_cmp++; if (mem_r_data !== 32'h0) begin n_err++; $display("FAIL txdata_read: got %h expected 0", mem_r_data); end
      end
      if (i == 1) begin
        n_cmp++; if (io_valid !== 1'b1) begin n_err++; $display("FAIL valid_after_push: got %b expected 1", io_valid); end
        n_cmp++; if (io_data !== 32'hA1) begin n_err++; $display("FAIL head_first: got %h expected %h", io_data, 32'hA1); end
      end
    end
    @(negedge clk);
    mem_w_en = 1'b0; mem_addr = STATUS;
    #1;
    n_cmp++; if (mem_r_data !== 32'h0001_0004) begin n_err++; $display("FAIL status_full: got %h expected %h", mem_r_data, 32'h0001_0004); end
    mem_w_en = 1'b1; mem_addr = TXDATA; mem_w_data = 32'hA5;
    @(negedge clk);
    mem_w_en = 1'b0; mem_addr = STATUS;
    #1;
    n_cmp++; if (mem_r_data !== 32'h8001_0004) begin n_err++; $display("FAIL status_overflow: got %h expected %h", mem_r_data, 32'h8001_0004); end
    n_cmp++; if (irq_ovf !== 1'b1) begin n_err++; $display("FAIL irq_set: got %b expected 1", irq_ovf); end
    n_cmp++; if (io_data !== 32'hA1) begin n_err++; $display("FAIL head_held: got %h expected %h", io_data, 32'hA1); end
  endtask

  task automatic test_drain();
    logic [31:0] exp [4];
    exp[0] = 32'hA1; exp[1] = 32'hA2; exp[2] = 32'hA3; exp[3] = 32'hA4;
    io_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) @(negedge clk);
      #1;
      n_cmp++; if (io_data !== exp[i] || io_valid !== 1'b1) begin n_err++; $display("FAIL drain_%0d: got %h/%b expected %h/1", i, io_data, io_valid, exp[i]); end
    end
    @(negedge clk);
    io_ready = 1'b0; mem_addr = STATUS;
    #1;
    n_cmp++; if (io_valid !== 1'b0) begin n_err++; $display("FAIL drained_valid: got %b expected 0", io_valid); end
    n_cmp++; if (mem_r_data !== 32'h8002_0000) begin n_err++; $display("FAIL status_drained: got %h expected %h", mem_r_data, 32'h8002_0000); end
    mem_w_en = 1'b1; mem_w_data = 32'h0000_0001;
    @(negedge clk);
    mem_w_en = 1'b0;
    #1;
    n_cmp++; if (irq_ovf !== 1'b1) begin n_err++; $display("FAIL irq_no_clear_bit31_0: got %b expected 1", irq_ovf); end
    mem_w_en = 1'b1; mem_w_data = 32'h8000_0000;
    @(negedge clk);
    mem_w_en = 1'b0;
    #1;
    n_cmp++; if (mem_r_data !== 32'h0002_0000) begin n_err++; $display("FAIL status_cleared: got %h expected %h", mem_r_data, 32'h0002_0000); end
    n_cmp++; if (irq_ovf !== 1'b0) begin n_err++; $display("FAIL irq_cleared: got %b expected 0", irq_ovf); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp [4];
    exp[0] = 32'hA2; exp[1] = 32'hA3; exp[2] = 32'hA4; exp[3] = 32'hB0;
    io_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      mem_w_en = 1'b1; mem_addr = TXDATA; mem_w_data = 32'hA1 + 32'(i);
    end
    @(negedge clk);
    io_ready = 1'b1; mem_w_data = 32'hB0;
    @(negedge clk);
    mem_w_en = 1'b0; mem_addr = STATUS;
    #1;
    n_cmp++; if (mem_r_data !== 32'h0001_0004) begin n_err++; $display("FAIL full_push_pop_status: got %h expected %h", mem_r_data, 32'h0001_0004); end
    n_cmp++; if (irq_ovf !== 1'b0) begin n_err++; $display("FAIL full_push_pop_irq: got %b expected 0", irq_ovf); end
    for (int i = 0; i < 4; i++) begin
      if (i > 0) @(negedge clk);
      #1;
      n_cmp++; if (io_data !== exp[i] || io_valid !== 1'b1) begin n_err++; $display("FAIL b2b_drain_%0d: got %h/%b expected %h/1", i, io_data, io_valid, exp[i]); end
    end
    @(negedge clk);
    io_ready = 1'b0;
    #1;
    n_cmp++; if (io_valid !== 1'b0) begin n_err++; $display("FAIL b2b_empty: got %b expected 0", io_valid); end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    mem_w_en = 1'b1; mem_addr = TXDATA; mem_w_data = 32'hC1;
    @(negedge clk);
    mem_w_data = 32'hC2;
    @(negedge clk);
    mem_w_en = 1'b0; io_ready = 1'b1;
    @(negedge clk);
    #1;
    n_cmp++; if (io_data !== 32'hC2) begin n_err++; $display("FAIL mid_drain_head: got %h expected %h", io_data, 32'hC2); end
    io_ready = 1'b0; rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; mem_addr = STATUS;
    #1;
    n_cmp++; if (io_valid !== 1'b0) begin n_err++; $display("FAIL rst_mid_valid: got %b expected 0", io_valid); end
    n_cmp++; if (mem_r_data !== 32'h0002_0000) begin n_err++; $display("FAIL rst_mid_status: got %h expected %h", mem_r_data, 32'h0002_0000); end
    n_cmp++; if (io_data !== 32'h0) begin n_err++; $display("FAIL rst_mid_io_data: got %h expected 0", io_data); end
    mem_addr = 32'h10;
    #1;
    n_cmp++; if (mem_r_data !== 32'h1234_5678) begin n_err++; $display("FAIL ram_retained: got %h expected %h", mem_r_data, 32'h1234_5678); end
  endtask

  initial begin
    test_reset();
    test_ram();
    test_fifo_fill();
    test_drain();
    test_back_to_back();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
